// File: rtl/dense_issue_scheduler.sv
// Paces buffered feature words into a time-multiplexed dense layer: one issue per II cycles at most,
// with the number of words inside the layer capped. Optional counters: define DENSE_SCHED_STATS_EN.
module dense_issue_scheduler #(
   parameter int DATA_W       = 128,
   parameter int II           = 63,
   parameter int FIFO_DEPTH   = 4,
   parameter int MAX_INFLIGHT = 2
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                s_vld,
   output logic                                s_rdy,
   input  logic [DATA_W-1:0]                   s_data,
   output logic                                layer_vld_in,
   output logic [DATA_W-1:0]                   layer_data_in,
   input  logic                                layer_vld_out,
   output logic [$clog2(FIFO_DEPTH):0]         fifo_level,
   output logic [$clog2(MAX_INFLIGHT):0]       inflight,
   output logic                                err
`ifdef DENSE_SCHED_STATS_EN
   ,
   output logic [31:0]                         issue_cnt,
   output logic [31:0]                         stall_cnt
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int IW = $clog2(MAX_INFLIGHT) + 1;
   localparam int CW = $clog2(II);

   localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
   localparam logic [LW-1:0] LVL_ZERO = LW'(0);
   localparam logic [IW-1:0] INF_MAX  = IW'(MAX_INFLIGHT);
   localparam logic [IW-1:0] INF_ZERO = IW'(0);
   localparam logic [CW-1:0] CD_LOAD  = CW'(II - 1);
   localparam logic [CW-1:0] CD_ZERO  = CW'(0);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_COOL  = 2'd2;

   logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [LW-1:0]     r_level;
   logic [CW-1:0]     r_cd;
   logic [IW-1:0]     r_inflight;
   logic              r_err;
   logic              r_vld_in;
   logic [DATA_W-1:0] r_data_in;
   logic [1:0]        r_state;

   logic              w_push;
   logic              w_issue;
   logic              w_retire;
   logic              w_spurious;
   logic [LW-1:0]     w_level_next;
   logic [IW-1:0]     w_inflight_next;
   logic [CW-1:0]     w_cd_next;
   logic [1:0]        w_state_next;

   assign s_rdy      = (r_level != LVL_FULL) && !rst;
   assign w_push     = s_vld && s_rdy;
   // Issue decision looks only at registered state, so a word pushed this edge issues next edge.
   assign w_issue    = (r_level != LVL_ZERO) && (r_cd == CD_ZERO) &&
                       (r_inflight < INF_MAX) && (r_state != ST_ISSUE);
   assign w_retire   = layer_vld_out && (r_inflight != INF_ZERO);
   assign w_spurious = layer_vld_out && (r_inflight == INF_ZERO);

   // Occupancy and in-flight count bookkeeping.
   always_comb begin
      w_level_next    = r_level;
      w_inflight_next = r_inflight;
      case ({w_push, w_issue})
         2'b10:   w_level_next = r_level + LW'(1);
         2'b01:   w_level_next = r_level - LW'(1);
         default: w_level_next = r_level;
      endcase
      case ({w_issue, w_retire})
         2'b10:   w_inflight_next = r_inflight + IW'(1);
         2'b01:   w_inflight_next = r_inflight - IW'(1);
         default: w_inflight_next = r_inflight;
      endcase
   end

   // Cooldown counter and pacing state machine.
   always_comb begin
      w_cd_next    = r_cd;
      w_state_next = r_state;
      if (w_issue) begin
         w_cd_next = CD_LOAD;
      end else if (r_cd != CD_ZERO) begin
         w_cd_next = r_cd - CW'(1);
      end else begin
         w_cd_next = r_cd;
      end
      case (r_state)
         ST_IDLE:  w_state_next = w_issue ? ST_ISSUE : ST_IDLE;
         ST_ISSUE: w_state_next = (w_cd_next != CD_ZERO) ? ST_COOL : ST_IDLE;
         ST_COOL: begin
            if (w_issue) begin
               w_state_next = ST_ISSUE;
            end else if (w_cd_next == CD_ZERO) begin
               w_state_next = ST_IDLE;
            end else begin
               w_state_next = ST_COOL;
            end
         end
         default:  w_state_next = ST_IDLE;
      endcase
   end

   // FIFO storage; contents need no reset since the level gates every read.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= s_data;
      end
   end

   // Control registers and registered layer-side outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= AW'(0);
         r_rd_ptr   <= AW'(0);
         r_level    <= LVL_ZERO;
         r_cd       <= CD_ZERO;
         r_inflight <= INF_ZERO;
         r_err      <= 1'b0;
         r_vld_in   <= 1'b0;
         r_data_in  <= DATA_W'(0);
         r_state    <= ST_IDLE;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_issue) begin
            r_rd_ptr  <= r_rd_ptr + AW'(1);
            r_data_in <= r_mem[r_rd_ptr];
         end
         if (w_spurious) begin
            r_err <= 1'b1;
         end
         r_level    <= w_level_next;
         r_inflight <= w_inflight_next;
         r_cd       <= w_cd_next;
         r_state    <= w_state_next;
         r_vld_in   <= w_issue;
      end
   end

   assign layer_vld_in  = r_vld_in;
   assign layer_data_in = r_data_in;
   assign fifo_level    = r_level;
   assign inflight      = r_inflight;
   assign err           = r_err;

`ifdef DENSE_SCHED_STATS_EN
   logic [31:0] r_issue_cnt;
   logic [31:0] r_stall_cnt;
   logic        w_stall;

   assign w_stall = (r_level != LVL_ZERO) && (r_cd == CD_ZERO) && (r_inflight >= INF_MAX);

   // Saturating issue and cap-stall counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_issue_cnt <= 32'd0;
         r_stall_cnt <= 32'd0;
      end else begin
         if (w_issue && (r_issue_cnt != 32'hFFFF_FFFF)) begin
            r_issue_cnt <= r_issue_cnt + 32'd1;
         end
         if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
      end
   end

   assign issue_cnt = r_issue_cnt;
   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_dense_issue_scheduler.sv
// Randomized scoreboard bench for dense_issue_scheduler against a timestamp-based reference model.
module tb_dense_issue_scheduler;
   localparam int DW    = 128;
   localparam int II    = 63;
   localparam int DEPTH = 4;
   localparam int MAXI  = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          s_vld = 1'b0;
   logic          s_rdy;
   logic [DW-1:0] s_data = '0;
   logic          layer_vld_in;
   logic [DW-1:0] layer_data_in;
   logic          layer_vld_out = 1'b0;
   logic [2:0]    fifo_level;
   logic [1:0]    inflight;
   logic          err;
`ifdef DENSE_SCHED_STATS_EN
   logic [31:0]   issue_cnt;
   logic [31:0]   stall_cnt;
`endif

   dense_issue_scheduler #(.DATA_W(DW), .II(II), .FIFO_DEPTH(DEPTH), .MAX_INFLIGHT(MAXI)) dut (
      .clk(clk), .rst(rst), .s_vld(s_vld), .s_rdy(s_rdy), .s_data(s_data),
      .layer_vld_in(layer_vld_in), .layer_data_in(layer_data_in), .layer_vld_out(layer_vld_out),
      .fifo_level(fifo_level), .inflight(inflight), .err(err)
`ifdef DENSE_SCHED_STATS_EN
      , .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
`endif
   );

   typedef struct {
      logic [DW-1:0] d;
      int            e;
   } exp_t;

   int            checks = 0;
   int            errors = 0;
   int            edge_cnt = 0;
   bit            chk_en = 1'b0;
   exp_t          exp_q[$];
   exp_t          mon_x;
   logic [DW-1:0] m_q[$];
   int            m_inf = 0;
   bit            m_err = 1'b0;
   bit            m_vin = 1'b0;
   logic [DW-1:0] m_dout = '0;
   int            m_last = -1000;

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_cnt, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Drive one cycle of inputs and advance the reference model to the state after the next edge.
   task automatic step(bit v, logic [DW-1:0] d, bit ret, bit r);
      int lvl;
      bit iss;
      bit dec;
      @(negedge clk);
      s_vld = v; s_data = d; layer_vld_out = ret; rst = r;
      lvl = m_q.size();
      if (r) begin
         m_q.delete();
         m_inf = 0; m_err = 1'b0; m_vin = 1'b0; m_dout = '0; m_last = -1000;
      end else begin
         iss = (lvl > 0) && ((edge_cnt + 1 - m_last) >= II) && (m_inf < MAXI);
         dec = ret && (m_inf > 0);
         if (ret && (m_inf == 0)) m_err = 1'b1;
         if (iss) begin
            m_dout = m_q.pop_front();
            exp_q.push_back('{m_dout, edge_cnt + 1});
            m_last = edge_cnt + 1;
         end
         m_vin = iss;
         if (v && (lvl < DEPTH)) m_q.push_back(d);
         m_inf = m_inf + int'(iss) - int'(dec);
      end
      chk_en = 1'b1;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
   endtask

   // Monitor: compares every cycle and pops the scoreboard whenever the DUT issues.
   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         check("vld_in", 128'(layer_vld_in), 128'(m_vin));
         if (layer_vld_in === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL issue_unexpected at edge %0d: got issue of %0h expected none", edge_cnt, layer_data_in);
            end else begin
               mon_x = exp_q.pop_front();
               check("issue_data", layer_data_in, mon_x.d);
               check("issue_edge", 128'(edge_cnt), 128'(mon_x.e));
            end
         end
         check("data_hold", layer_data_in, m_dout);
         check("fifo_level", 128'(fifo_level), 128'(m_q.size()));
         check("inflight", 128'(inflight), 128'(m_inf));
         check("err", 128'(err), 128'(m_err));
         check("s_rdy", 128'(s_rdy), 128'((m_q.size() < DEPTH) && !rst));
      end
   end

   initial begin
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b1);
      // single word with minimum latency
      idle(8);
      step(1'b1, 128'h0123456789ABCDEF0123456789ABCDEF, 1'b0, 1'b0);
      idle(80);
      step(1'b0, '0, 1'b1, 1'b0);
      // burst into a full FIFO, results trickling back
      for (int i = 0; i < 6; i++) step(1'b1, rnd(), 1'b0, 1'b0);
      for (int i = 0; i < 450; i++) step(1'b0, '0, (m_inf > 0) && ($urandom_range(0, 19) == 0), 1'b0);
      // inflight cap then release
      step(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, rnd(), 1'b0, 1'b0);
      idle(200);
      step(1'b0, '0, 1'b1, 1'b0);
      idle(100);
      // spurious result
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b1, 1'b0);
      idle(5);
      // reset with a backlog
      step(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, rnd(), 1'b0, 1'b0);
      idle(30);
      step(1'b0, '0, 1'b0, 1'b1);
      idle(3);
      step(1'b1, rnd(), 1'b0, 1'b0);
      idle(70);
      // random traffic
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 2) == 0, rnd(), $urandom_range(0, 24) == 0, $urandom_range(0, 599) == 0);
      for (int i = 0; i < 300; i++) step(1'b0, '0, (m_inf > 0) && ($urandom_range(0, 9) == 0), 1'b0);
      idle(2);
      check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
